// File: rtl/accel_regs_pkg.sv
// Shared definitions for the accelerator job launcher: register map, STATUS bits,
// completion codes and the state encodings of the launcher and transfer engine.
package accel_regs_pkg;

  // Register offsets inside the accelerator's 64-byte window.
  localparam logic [7:0] RegCtrl   = 8'h00;
  localparam logic [7:0] RegStatus = 8'h04;
  localparam logic [7:0] RegM      = 8'h08;
  localparam logic [7:0] RegK      = 8'h0C;
  localparam logic [7:0] RegN      = 8'h10;

  localparam logic [31:0] CtrlStart = 32'h0000_0001;

  localparam int unsigned StatusBusyBit = 0;
  localparam int unsigned StatusDoneBit = 1;

  localparam logic [1:0] RespOkay = 2'b00;

  typedef enum logic [1:0] {
    ErrOk      = 2'b00,
    ErrBus     = 2'b01,
    ErrTimeout = 2'b10,
    ErrZero    = 2'b11
  } done_err_e;

  typedef enum logic [2:0] {
    StIdle,
    StWrite,
    StPollWait,
    StRead,
    StDone
  } launch_state_e;

  typedef enum logic [2:0] {
    XfIdle,
    XfWrAddr,
    XfWrResp,
    XfRdAddr,
    XfRdData
  } xfer_state_e;

endpackage

// File: rtl/accel_axil_xfer.sv
// Single AXI4-Lite transaction engine. A request is accepted when idle or in the
// cycle the previous transaction completes, so back-to-back writes need no gap.
module accel_axil_xfer
  import accel_regs_pkg::*;
#(
  parameter int unsigned AddrWidth = 6,
  parameter int unsigned DataWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_i,
  input  logic                 we_i,
  input  logic [AddrWidth-1:0] addr_i,
  input  logic [DataWidth-1:0] wdata_i,
  output logic                 done_o,
  output logic [1:0]           resp_o,
  output logic [DataWidth-1:0] rdata_o,
  output logic [AddrWidth-1:0] awaddr_o,
  output logic                 awvalid_o,
  input  logic                 awready_i,
  output logic [DataWidth-1:0] wdata_o,
  output logic                 wvalid_o,
  input  logic                 wready_i,
  input  logic [1:0]           bresp_i,
  input  logic                 bvalid_i,
  output logic                 bready_o,
  output logic [AddrWidth-1:0] araddr_o,
  output logic                 arvalid_o,
  input  logic                 arready_i,
  input  logic [DataWidth-1:0] rdata_i,
  input  logic [1:0]           rresp_i,
  input  logic                 rvalid_i,
  output logic                 rready_o
);

  xfer_state_e          state_q, state_d;
  logic                 awvalid_q, awvalid_d;
  logic                 wvalid_q, wvalid_d;
  logic                 arvalid_q, arvalid_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [DataWidth-1:0] wdata_q, wdata_d;

  // Phase sequencing; AW and W retire independently before the response phase.
  always_comb begin
    state_d   = state_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    arvalid_d = arvalid_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    done_o    = 1'b0;
    unique case (state_q)
      XfIdle: ;
      XfWrAddr: begin
        if (awready_i) awvalid_d = 1'b0;
        if (wready_i)  wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) state_d = XfWrResp;
      end
      XfWrResp: begin
        if (bvalid_i) begin
          done_o  = 1'b1;
          state_d = XfIdle;
        end
      end
      XfRdAddr: begin
        if (arready_i) begin
          arvalid_d = 1'b0;
          state_d   = XfRdData;
        end
      end
      XfRdData: begin
        if (rvalid_i) begin
          done_o  = 1'b1;
          state_d = XfIdle;
        end
      end
      default: state_d = XfIdle;
    endcase
    if (req_i && (state_q == XfIdle || done_o)) begin
      addr_d = addr_i;
      if (we_i) begin
        wdata_d   = wdata_i;
        awvalid_d = 1'b1;
        wvalid_d  = 1'b1;
        state_d   = XfWrAddr;
      end else begin
        arvalid_d = 1'b1;
        state_d   = XfRdAddr;
      end
    end
  end

  // State and channel registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= XfIdle;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      arvalid_q <= arvalid_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
    end
  end

  assign awaddr_o  = addr_q;
  assign araddr_o  = addr_q;
  assign awvalid_o = awvalid_q;
  assign wvalid_o  = wvalid_q;
  assign wdata_o   = wdata_q;
  assign arvalid_o = arvalid_q;
  assign bready_o  = (state_q == XfWrResp);
  assign rready_o  = (state_q == XfRdData);
  assign resp_o    = (state_q == XfRdData) ? rresp_i : bresp_i;
  assign rdata_o   = rdata_i;

endmodule

// File: rtl/accel_job_launcher.sv
// Launches one matrix-multiply job: writes M, K, N and CTRL.start, then polls STATUS
// and watches the done interrupt until completion, bus error or timeout.
module accel_job_launcher
  import accel_regs_pkg::*;
#(
  parameter int unsigned C_M_AXI_ADDR_WIDTH = 6,
  parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
  parameter int unsigned POLL_INTERVAL      = 16,
  parameter int unsigned TIMEOUT_CYCLES     = 65536
) (
  input  logic                            s_axi_aclk,
  input  logic                            s_axi_aresetn,
  input  logic                            job_valid,
  output logic                            job_ready,
  input  logic [31:0]                     job_m,
  input  logic [31:0]                     job_k,
  input  logic [31:0]                     job_n,
  output logic                            done_valid,
  input  logic                            done_ready,
  output logic [1:0]                      done_err,
  output logic [31:0]                     done_status,
  input  logic                            irq_done,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic                            m_axi_awvalid,
  input  logic                            m_axi_awready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                            m_axi_wvalid,
  input  logic                            m_axi_wready,
  input  logic [1:0]                      m_axi_bresp,
  input  logic                            m_axi_bvalid,
  output logic                            m_axi_bready,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic                            m_axi_arvalid,
  input  logic                            m_axi_arready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]                      m_axi_rresp,
  input  logic                            m_axi_rvalid,
  output logic                            m_axi_rready
);

  launch_state_e state_q, state_d;
  logic [31:0]   m_q, m_d, k_q, k_d, n_q, n_d;
  logic [1:0]    wr_idx_q, wr_idx_d;
  logic [31:0]   poll_cnt_q, poll_cnt_d;
  logic [31:0]   tmo_cnt_q, tmo_cnt_d;
  logic          irq_flag_q, irq_flag_d;
  logic          seen_busy_q, seen_busy_d;
  done_err_e     done_err_q, done_err_d;
  logic [31:0]   done_status_q, done_status_d;

  logic                          xfer_req, xfer_we, xfer_done;
  logic [C_M_AXI_ADDR_WIDTH-1:0] xfer_addr;
  logic [C_M_AXI_DATA_WIDTH-1:0] xfer_wdata, xfer_rdata;
  logic [1:0]                    xfer_resp;
  logic [1:0]                    wr_sel;
  logic [7:0]                    wr_off;
  logic [31:0]                   wr_val;
  logic [31:0]                   rd_word;
  logic                          tmo_hit, rd_complete;

  // Register/value for the write about to be issued; slot 0 is launched from idle.
  always_comb begin
    wr_sel = (state_q == StIdle) ? 2'd0 : wr_idx_q + 2'd1;
    unique case (wr_sel)
      2'd0:    begin wr_off = RegM;    wr_val = job_m;     end
      2'd1:    begin wr_off = RegK;    wr_val = k_q;       end
      2'd2:    begin wr_off = RegN;    wr_val = n_q;       end
      default: begin wr_off = RegCtrl; wr_val = CtrlStart; end
    endcase
  end

  assign tmo_hit     = tmo_cnt_q >= 32'(TIMEOUT_CYCLES);
  assign rd_word     = 32'(xfer_rdata);
  // Busy falling only counts once a previous read in this job has seen busy.
  assign rd_complete = irq_flag_q || irq_done || rd_word[StatusDoneBit] ||
                       (!rd_word[StatusBusyBit] && seen_busy_q);

  // Launcher sequencing, completion detection and timeout.
  always_comb begin
    state_d       = state_q;
    m_d           = m_q;
    k_d           = k_q;
    n_d           = n_q;
    wr_idx_d      = wr_idx_q;
    poll_cnt_d    = poll_cnt_q;
    tmo_cnt_d     = tmo_cnt_q;
    irq_flag_d    = irq_flag_q;
    seen_busy_d   = seen_busy_q;
    done_err_d    = done_err_q;
    done_status_d = done_status_q;
    xfer_req      = 1'b0;
    xfer_we       = 1'b1;
    xfer_addr     = C_M_AXI_ADDR_WIDTH'(wr_off);
    xfer_wdata    = C_M_AXI_DATA_WIDTH'(wr_val);

    if (state_q == StPollWait || state_q == StRead) begin
      if (tmo_cnt_q != 32'hFFFF_FFFF) tmo_cnt_d = tmo_cnt_q + 32'd1;
      irq_flag_d = irq_flag_q | irq_done;
    end

    unique case (state_q)
      StIdle: begin
        if (job_valid) begin
          m_d           = job_m;
          k_d           = job_k;
          n_d           = job_n;
          wr_idx_d      = 2'd0;
          done_status_d = 32'd0;
          if (job_m == 32'd0 || job_k == 32'd0 || job_n == 32'd0) begin
            done_err_d = ErrZero;
            state_d    = StDone;
          end else begin
            xfer_req = 1'b1;
            state_d  = StWrite;
          end
        end
      end
      StWrite: begin
        if (xfer_done) begin
          if (xfer_resp != RespOkay) begin
            done_err_d = ErrBus;
            state_d    = StDone;
          end else if (wr_idx_q == 2'd3) begin
            // CTRL acknowledged: the job is running from here on.
            poll_cnt_d  = 32'(POLL_INTERVAL - 1);
            tmo_cnt_d   = 32'd0;
            irq_flag_d  = irq_done;
            seen_busy_d = 1'b0;
            state_d     = StPollWait;
          end else begin
            wr_idx_d = wr_idx_q + 2'd1;
            xfer_req = 1'b1;
          end
        end
      end
      StPollWait: begin
        if (irq_flag_q || irq_done) begin
          done_err_d = ErrOk;
          state_d    = StDone;
        end else if (tmo_hit) begin
          done_err_d = ErrTimeout;
          state_d    = StDone;
        end else if (poll_cnt_q == 32'd0) begin
          xfer_req  = 1'b1;
          xfer_we   = 1'b0;
          xfer_addr = C_M_AXI_ADDR_WIDTH'(RegStatus);
          state_d   = StRead;
        end else begin
          poll_cnt_d = poll_cnt_q - 32'd1;
        end
      end
      StRead: begin
        if (xfer_done) begin
          if (xfer_resp != RespOkay) begin
            done_err_d = ErrBus;
            state_d    = StDone;
          end else begin
            done_status_d = rd_word;
            if (rd_complete) begin
              done_err_d = ErrOk;
              state_d    = StDone;
            end else if (tmo_hit) begin
              done_err_d = ErrTimeout;
              state_d    = StDone;
            end else begin
              seen_busy_d = seen_busy_q | rd_word[StatusBusyBit];
              poll_cnt_d  = 32'(POLL_INTERVAL - 1);
              state_d     = StPollWait;
            end
          end
        end
      end
      StDone: begin
        if (done_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Launcher state registers.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state_q       <= StIdle;
      m_q           <= 32'd0;
      k_q           <= 32'd0;
      n_q           <= 32'd0;
      wr_idx_q      <= 2'd0;
      poll_cnt_q    <= 32'd0;
      tmo_cnt_q     <= 32'd0;
      irq_flag_q    <= 1'b0;
      seen_busy_q   <= 1'b0;
      done_err_q    <= ErrOk;
      done_status_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      m_q           <= m_d;
      k_q           <= k_d;
      n_q           <= n_d;
      wr_idx_q      <= wr_idx_d;
      poll_cnt_q    <= poll_cnt_d;
      tmo_cnt_q     <= tmo_cnt_d;
      irq_flag_q    <= irq_flag_d;
      seen_busy_q   <= seen_busy_d;
      done_err_q    <= done_err_d;
      done_status_q <= done_status_d;
    end
  end

  assign job_ready   = (state_q == StIdle);
  assign done_valid  = (state_q == StDone);
  assign done_err    = done_err_q;
  assign done_status = done_status_q;
  assign m_axi_wstrb = '1;

  accel_axil_xfer #(
    .AddrWidth(C_M_AXI_ADDR_WIDTH),
    .DataWidth(C_M_AXI_DATA_WIDTH)
  ) u_xfer (
    .clk_i    (s_axi_aclk),
    .rst_ni   (s_axi_aresetn),
    .req_i    (xfer_req),
    .we_i     (xfer_we),
    .addr_i   (xfer_addr),
    .wdata_i  (xfer_wdata),
    .done_o   (xfer_done),
    .resp_o   (xfer_resp),
    .rdata_o  (xfer_rdata),
    .awaddr_o (m_axi_awaddr),
    .awvalid_o(m_axi_awvalid),
    .awready_i(m_axi_awready),
    .wdata_o  (m_axi_wdata),
    .wvalid_o (m_axi_wvalid),
    .wready_i (m_axi_wready),
    .bresp_i  (m_axi_bresp),
    .bvalid_i (m_axi_bvalid),
    .bready_o (m_axi_bready),
    .araddr_o (m_axi_araddr),
    .arvalid_o(m_axi_arvalid),
    .arready_i(m_axi_arready),
    .rdata_i  (m_axi_rdata),
    .rresp_i  (m_axi_rresp),
    .rvalid_i (m_axi_rvalid),
    .rready_o (m_axi_rready)
  );

endmodule

// File: tb/tb_accel_job_launcher.sv
// Randomized bench for accel_job_launcher with a reactive AXI4-Lite slave and a
// scoreboard of expected register writes and completions.
module tb_accel_job_launcher;

  localparam int unsigned Poll = 4;
  localparam int unsigned Tmo  = 64;
  localparam int KIrq = 0, KFall = 1, KDoneBit = 2, KTmo = 3, KBus = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        job_valid = 1'b0, job_ready;
  logic [31:0] job_m = '0, job_k = '0, job_n = '0;
  logic        done_valid, done_ready = 1'b0;
  logic [1:0]  done_err;
  logic [31:0] done_status;
  logic        irq_done = 1'b0;
  logic [5:0]  awaddr, araddr;
  logic        awvalid, awready = 1'b0, wvalid, wready = 1'b0;
  logic [31:0] wdata, rdata = '0;
  logic [3:0]  wstrb;
  logic [1:0]  bresp = '0, rresp = '0;
  logic        bvalid = 1'b0, bready, arvalid, arready = 1'b0, rvalid = 1'b0, rready;

  always #5 clk = ~clk;

  accel_job_launcher #(
    .C_M_AXI_ADDR_WIDTH(6),
    .C_M_AXI_DATA_WIDTH(32),
    .POLL_INTERVAL     (Poll),
    .TIMEOUT_CYCLES    (Tmo)
  ) dut (
    .s_axi_aclk   (clk),
    .s_axi_aresetn(rst_n),
    .job_valid    (job_valid),
    .job_ready    (job_ready),
    .job_m        (job_m),
    .job_k        (job_k),
    .job_n        (job_n),
    .done_valid   (done_valid),
    .done_ready   (done_ready),
    .done_err     (done_err),
    .done_status  (done_status),
    .irq_done     (irq_done),
    .m_axi_awaddr (awaddr),
    .m_axi_awvalid(awvalid),
    .m_axi_awready(awready),
    .m_axi_wdata  (wdata),
    .m_axi_wstrb  (wstrb),
    .m_axi_wvalid (wvalid),
    .m_axi_wready (wready),
    .m_axi_bresp  (bresp),
    .m_axi_bvalid (bvalid),
    .m_axi_bready (bready),
    .m_axi_araddr (araddr),
    .m_axi_arvalid(arvalid),
    .m_axi_arready(arready),
    .m_axi_rdata  (rdata),
    .m_axi_rresp  (rresp),
    .m_axi_rvalid (rvalid),
    .m_axi_rready (rready)
  );

  typedef struct {
    logic [1:0]  err;
    logic [31:0] status;
    bit          no_reads;
  } exp_done_t;

  exp_done_t   done_q[$];
  logic [5:0]  exp_waddr_q[$];
  logic [31:0] exp_wdata_q[$];
  logic [31:0] status_q[$];

  int unsigned n_pass = 0, n_checks = 0;
  int          cfg_aw_wait = 0, cfg_w_wait = 0, cfg_b_wait = 0, cfg_ar_wait = 0, cfg_r_wait = 0;
  int          cfg_err_idx = -1, cfg_irq_delay = -1;
  int          wr_cnt = 0, ar_cnt = 0, done_seen = 0;
  bit          aborted = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Reactive slave: per-job wait states, scripted STATUS words, optional bresp error
  // and an irq pulse a fixed number of cycles after the CTRL write response.
  initial begin
    int  aw_c, w_c, b_c, ar_c, r_c, irq_c;
    bit  aw_got, w_got, ar_got, irq_armed;
    aw_c = 0; w_c = 0; b_c = 0; ar_c = 0; r_c = 0; irq_c = 0;
    aw_got = 0; w_got = 0; ar_got = 0; irq_armed = 0;
    forever begin
      @(posedge clk);
      #1;
      done_ready = 1'($urandom_range(0, 1));
      if (!rst_n) begin
        awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0; irq_done = 0;
        aw_got = 0; w_got = 0; ar_got = 0; irq_armed = 0;
        aw_c = 0; w_c = 0; b_c = 0; ar_c = 0; r_c = 0;
        continue;
      end
      if (irq_done) irq_done = 0;
      if (irq_armed) begin
        irq_c++;
        if (irq_c == cfg_irq_delay) begin irq_done = 1; irq_armed = 0; end
      end
      if (bvalid) begin
        bvalid = 0; aw_got = 0; w_got = 0;
        if (wr_cnt == 3 && bresp == 2'b00 && cfg_irq_delay > 0) begin
          irq_armed = 1; irq_c = 0;
        end
        wr_cnt++;
      end else if (aw_got && w_got) begin
        if (b_c >= cfg_b_wait) begin
          bvalid = 1; b_c = 0;
          bresp = (wr_cnt == cfg_err_idx) ? 2'b10 : 2'b00;
        end else b_c++;
      end
      if (awready) begin awready = 0; aw_got = 1; end
      else if (awvalid && !aw_got) begin
        if (aw_c >= cfg_aw_wait) begin awready = 1; aw_c = 0; end else aw_c++;
      end
      if (wready) begin wready = 0; w_got = 1; end
      else if (wvalid && !w_got) begin
        if (w_c >= cfg_w_wait) begin wready = 1; w_c = 0; end else w_c++;
      end
      if (rvalid) begin rvalid = 0; ar_got = 0; end
      else if (ar_got) begin
        if (r_c >= cfg_r_wait) begin
          rvalid = 1; r_c = 0; rresp = 2'b00;
          rdata = (status_q.size() > 1) ? status_q.pop_front() : status_q[0];
        end else r_c++;
      end
      if (arready) begin arready = 0; ar_got = 1; end
      else if (arvalid && !ar_got) begin
        if (ar_c >= cfg_ar_wait) begin arready = 1; ar_c = 0; end else ar_c++;
      end
    end
  end

  // Monitor: pairs AW/W handshakes into writes, checks reads and completions.
  initial begin
    logic [5:0]  mon_aw;
    logic [31:0] mon_w;
    bit          aw_have, w_have, prev_dv, prev_hs;
    logic [1:0]  prev_err;
    logic [31:0] prev_stat;
    exp_done_t   e;
    aw_have = 0; w_have = 0; prev_dv = 0; prev_hs = 0; prev_err = '0; prev_stat = '0;
    mon_aw = '0; mon_w = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin aw_have = 0; w_have = 0; prev_dv = 0; continue; end
      if (awvalid && awready) begin
        check("aw_single_handshake", 32'(aw_have), 32'd0);
        mon_aw = awaddr; aw_have = 1;
      end
      if (wvalid && wready) begin
        check("w_single_handshake", 32'(w_have), 32'd0);
        check("wstrb", 32'(wstrb), 32'hF);
        mon_w = wdata; w_have = 1;
      end
      if (aw_have && w_have) begin
        check("write_expected", 32'(exp_waddr_q.size() != 0), 32'd1);
        if (exp_waddr_q.size() != 0) begin
          check("write_addr", 32'(mon_aw), 32'(exp_waddr_q.pop_front()));
          check("write_data", mon_w, exp_wdata_q.pop_front());
        end
        aw_have = 0; w_have = 0;
      end
      if (arvalid && arready) begin
        check("read_addr", 32'(araddr), 32'h04);
        ar_cnt++;
      end
      if (prev_dv && !prev_hs) begin
        check("done_valid_held", 32'(done_valid), 32'd1);
        check("done_err_stable", 32'(done_err), 32'(prev_err));
        check("done_status_stable", done_status, prev_stat);
      end
      prev_dv = done_valid; prev_hs = done_valid && done_ready;
      prev_err = done_err; prev_stat = done_status;
      if (done_valid && done_ready) begin
        check("done_expected", 32'(done_q.size() != 0), 32'd1);
        if (done_q.size() != 0) begin
          e = done_q.pop_front();
          check("done_err", 32'(done_err), 32'(e.err));
          check("done_status", done_status, e.status);
          check("writes_complete", 32'(exp_waddr_q.size()), 32'd0);
          if (e.no_reads) check("no_reads", 32'(ar_cnt), 32'd0);
        end
        done_seen++;
      end
    end
  end

  // Reference model for one job, then issue it and wait for its completion.
  task automatic run_job(input logic [31:0] m, k, n, input int kind, input int param,
                         input bit zero_fin);
    logic [31:0] bw, fin;
    logic [5:0]  addrs[4];
    logic [31:0] datas[4];
    exp_done_t   e;
    int          nwr, start, cyc;
    if (aborted) return;
    addrs[0] = 6'h08; addrs[1] = 6'h0C; addrs[2] = 6'h10; addrs[3] = 6'h00;
    datas[0] = m; datas[1] = k; datas[2] = n; datas[3] = 32'd1;
    bw = $urandom(); bw[1:0] = 2'b01;
    fin = zero_fin ? 32'd0 : $urandom();
    status_q.delete();
    cfg_irq_delay = -1; cfg_err_idx = -1; nwr = 4; e.no_reads = 0;
    case (kind)
      KIrq: begin status_q.push_back(bw); cfg_irq_delay = param; e.err = 2'b00; e.status = bw; end
      KFall: begin
        repeat (param) status_q.push_back(bw);
        fin[1:0] = 2'b00; status_q.push_back(fin); e.err = 2'b00; e.status = fin;
      end
      KDoneBit: begin
        repeat (param) status_q.push_back(bw);
        fin[1] = 1'b1; status_q.push_back(fin); e.err = 2'b00; e.status = fin;
      end
      KTmo: begin status_q.push_back(bw); e.err = 2'b10; e.status = bw; end
      default: begin
        status_q.push_back(bw); cfg_err_idx = param;
        e.err = 2'b01; e.status = 32'd0; nwr = param + 1; e.no_reads = 1;
      end
    endcase
    if (m == 0 || k == 0 || n == 0) begin
      e.err = 2'b11; e.status = 32'd0; nwr = 0; e.no_reads = 1; cfg_irq_delay = -1;
    end
    for (int i = 0; i < nwr; i++) begin
      exp_waddr_q.push_back(addrs[i]);
      exp_wdata_q.push_back(datas[i]);
    end
    done_q.push_back(e);
    wr_cnt = 0; ar_cnt = 0; start = done_seen;
    cyc = 0;
    while (!job_ready && cyc < 200) begin @(posedge clk); #1; cyc++; end
    job_m = m; job_k = k; job_n = n; job_valid = 1;
    @(posedge clk); #1;
    job_valid = 0;
    cyc = 0;
    while (done_seen == start && cyc < 3000) begin @(posedge clk); #1; cyc++; end
    check("done_arrived", 32'(done_seen != start), 32'd1);
    if (done_seen == start) aborted = 1;
  endtask

  function automatic logic [31:0] rand_size();
    return ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom_range(1, 4096));
  endfunction

  initial begin
    int kind, param, cyc;
    bit saw_dv;
    #23;
    check("rst_job_ready", 32'(job_ready), 32'd1);
    check("rst_valids", {28'd0, awvalid, wvalid, arvalid, done_valid}, 32'd0);
    check("rst_readies", {30'd0, bready, rready}, 32'd0);
    check("rst_addr_data", {20'd0, awaddr, araddr} | wdata, 32'd0);
    check("rst_done_err", 32'(done_err), 32'd0);
    check("rst_done_status", done_status, 32'd0);
    @(posedge clk); #1;
    rst_n = 1;
    repeat (2) @(posedge clk);
    #1;

    run_job(32'd16, 32'd16, 32'd16, KIrq, 40, 0);
    cfg_aw_wait = 3;
    run_job(32'd5, 32'd7, 32'd9, KIrq, 25, 0);
    cfg_aw_wait = 0;
    run_job(32'd3, 32'd4, 32'd5, KBus, 1, 0);
    run_job(32'd8, 32'd2, 32'd6, KFall, 1, 1);
    run_job(32'd2, 32'd2, 32'd2, KTmo, 0, 0);
    run_job(32'd0, 32'd4, 32'd4, KIrq, 30, 0);

    for (int j = 0; j < 30; j++) begin
      cfg_aw_wait = $urandom_range(0, 3); cfg_w_wait = $urandom_range(0, 3);
      cfg_b_wait = $urandom_range(0, 2); cfg_ar_wait = $urandom_range(0, 2);
      cfg_r_wait = $urandom_range(0, 2);
      kind = $urandom_range(0, 4);
      case (kind)
        KIrq:     param = $urandom_range(20, 40);
        KFall:    param = $urandom_range(1, 3);
        KDoneBit: param = $urandom_range(0, 3);
        KBus:     param = $urandom_range(0, 3);
        default:  param = 0;
      endcase
      run_job(rand_size(), rand_size(), rand_size(), kind, param, 0);
    end

    // Reset while the CTRL write is on the bus.
    if (!aborted) begin
      cfg_aw_wait = 3; cfg_w_wait = 3; cfg_b_wait = 0;
      status_q.delete(); status_q.push_back(32'h1); cfg_irq_delay = 20; cfg_err_idx = -1;
      wr_cnt = 0;
      for (int i = 0; i < 4; i++) begin
        exp_waddr_q.push_back((i == 0) ? 6'h08 : (i == 1) ? 6'h0C : (i == 2) ? 6'h10 : 6'h00);
        exp_wdata_q.push_back((i == 3) ? 32'd1 : 32'd8);
      end
      job_m = 8; job_k = 8; job_n = 8; job_valid = 1;
      @(posedge clk); #1;
      job_valid = 0;
      cyc = 0;
      while (!(awvalid && awaddr == 6'h00) && cyc < 300) begin @(posedge clk); #1; cyc++; end
      check("ctrl_write_seen", 32'(awvalid && awaddr == 6'h00), 32'd1);
      #1 rst_n = 0;
      #1;
      check("rst_mid_valids", {29'd0, awvalid, wvalid, arvalid}, 32'd0);
      exp_waddr_q.delete(); exp_wdata_q.delete();
      @(posedge clk); #1;
      rst_n = 1;
      #1;
      check("rst_mid_job_ready", 32'(job_ready), 32'd1);
      saw_dv = 0;
      repeat (40) begin @(posedge clk); #1; saw_dv |= done_valid; end
      check("rst_mid_no_done", 32'(saw_dv), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
